// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, colour widths and sync-polarity type
package vga_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  localparam int COLOR_BITS_D = 3;
  localparam int COORD_W_D = 10;
  typedef enum logic {SYNC_ACT_LOW = 1'b0, SYNC_ACT_HIGH = 1'b1} sync_pol_e;
  function automatic int rgb_w(input int color_bits);
    return 3 * color_bits;
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel/line counters with visible, sync and frame/vblank strobes
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int COORD_W = COORD_W_D
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] h_count,
  output logic [COORD_W-1:0] v_count,
  output logic               visible,
  output logic               hs_on,
  output logic               vs_on,
  output logic               frame_top,
  output logic               vblank_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  logic [COORD_W-1:0] h_d, h_q, v_d, v_q;
  logic h_end, v_end;
  // next counter values: h wraps each line, v advances on h wrap and wraps per frame
  always_comb begin
    h_end = h_q == COORD_W'(H_TOTAL - 1);
    v_end = v_q == COORD_W'(V_TOTAL - 1);
    h_d = h_end ? '0 : h_q + COORD_W'(1);
    v_d = h_end ? (v_end ? '0 : v_q + COORD_W'(1)) : v_q;
  end
  // counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h_count = h_q;
  assign v_count = v_q;
  assign visible = (h_q < COORD_W'(H_ACTIVE)) && (v_q < COORD_W'(V_ACTIVE));
  assign hs_on = (h_q >= COORD_W'(H_ACTIVE + H_FP)) && (h_q < COORD_W'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on = (v_q >= COORD_W'(V_ACTIVE + V_FP)) && (v_q < COORD_W'(V_ACTIVE + V_FP + V_SYNC));
  assign frame_top = (h_q == '0) && (v_q == '0);
  assign vblank_start = h_end && (v_q == COORD_W'(V_ACTIVE - 1));
endmodule

// File: rtl/vga_sprite_raster.sv
// vga_sprite_raster: sprite compositor over VGA timing; VGA_GRID_EN adds a grid overlay
module vga_sprite_raster
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP = H_FP_D,
  parameter int H_SYNC = H_SYNC_D,
  parameter int H_BP = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP = V_FP_D,
  parameter int V_SYNC = V_SYNC_D,
  parameter int V_BP = V_BP_D,
  parameter int COORD_W = COORD_W_D,
  parameter int COLOR_BITS = COLOR_BITS_D,
  parameter int N_SPRITES = 4,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
`ifdef VGA_GRID_EN
  parameter int GRID_SIZE = 32,
  parameter logic [3*COLOR_BITS-1:0] GRID_COLOR = 9'b100100100,
`endif
  parameter sync_pol_e HS_POL = SYNC_ACT_LOW,
  parameter sync_pol_e VS_POL = SYNC_ACT_LOW
) (
  input  logic                              clk,
  input  logic                              rstN,
  input  logic [N_SPRITES*COORD_W-1:0]      spriteX,
  input  logic [N_SPRITES*COORD_W-1:0]      spriteY,
  input  logic [N_SPRITES*3*COLOR_BITS-1:0] spriteColor,
  input  logic [N_SPRITES-1:0]              spriteEn,
  input  logic [3*COLOR_BITS-1:0]           bgColor,
  output logic [COLOR_BITS-1:0]             vgaR,
  output logic [COLOR_BITS-1:0]             vgaG,
  output logic [COLOR_BITS-1:0]             vgaB,
  output logic                              vgaHs,
  output logic                              vgaVs,
  output logic                              activeVideo,
  output logic                              frameStart
);
  localparam int RGB_W = rgb_w(COLOR_BITS);
  localparam int CW1 = COORD_W + 1;
  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic vis, hs_on, vs_on, frame_top, vblank_start;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .COORD_W(COORD_W)
  ) u_timing (
    .clk(clk), .rst_n(rstN), .h_count(h_cnt), .v_count(v_cnt), .visible(vis),
    .hs_on(hs_on), .vs_on(vs_on), .frame_top(frame_top), .vblank_start(vblank_start)
  );
  logic [N_SPRITES*COORD_W-1:0] sx_d, sx_q, sy_d, sy_q;
  logic [N_SPRITES*RGB_W-1:0] sc_d, sc_q;
  logic [N_SPRITES-1:0] en_d, en_q, hit_c, hit1_q;
  logic vis1_q, hs1_q, vs1_q, fs1_q;
  logic [RGB_W-1:0] col_d, col_q;
  logic hs_d, hs_q, vs_d, vs_q;
`ifdef VGA_GRID_EN
  logic [COORD_W-1:0] x1_q, y1_q;
`endif
  // shadow copies refresh only at the start of vertical blanking so a frame never tears
  always_comb begin
    sx_d = vblank_start ? spriteX : sx_q;
    sy_d = vblank_start ? spriteY : sy_q;
    sc_d = vblank_start ? spriteColor : sc_q;
    en_d = vblank_start ? spriteEn : en_q;
  end
  // shadow sprite state
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sx_q <= '0;
      sy_q <= '0;
      sc_q <= '0;
      en_q <= '0;
    end else begin
      sx_q <= sx_d;
      sy_q <= sy_d;
      sc_q <= sc_d;
      en_q <= en_d;
    end
  end
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_hit
    logic [CW1-1:0] sxe, sye;
    assign sxe = CW1'(sx_q[g*COORD_W +: COORD_W]);
    assign sye = CW1'(sy_q[g*COORD_W +: COORD_W]);
    assign hit_c[g] = en_q[g]
                    && (CW1'(h_cnt) >= sxe) && (CW1'(h_cnt) < sxe + CW1'(SPRITE_W))
                    && (CW1'(v_cnt) >= sye) && (CW1'(v_cnt) < sye + CW1'(SPRITE_H));
  end
  // stage 1: coordinates, visible flag, raw sync and hit vector
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vis1_q <= 1'b0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      fs1_q <= 1'b0;
      hit1_q <= '0;
`ifdef VGA_GRID_EN
      x1_q <= '0;
      y1_q <= '0;
`endif
    end else begin
      vis1_q <= vis;
      hs1_q <= hs_on;
      vs1_q <= vs_on;
      fs1_q <= frame_top;
      hit1_q <= hit_c;
`ifdef VGA_GRID_EN
      x1_q <= h_cnt;
      y1_q <= v_cnt;
`endif
    end
  end
  // colour priority: lowest-index sprite, then grid, then background; blanked outside the visible area
  always_comb begin
    col_d = bgColor;
`ifdef VGA_GRID_EN
    col_d = ((x1_q & COORD_W'(GRID_SIZE - 1)) == '0) || ((y1_q & COORD_W'(GRID_SIZE - 1)) == '0) ? GRID_COLOR : bgColor;
`endif
    for (int i = N_SPRITES - 1; i >= 0; i--) col_d = hit1_q[i] ? sc_q[i*RGB_W +: RGB_W] : col_d;
    col_d = vis1_q ? col_d : '0;
    hs_d = logic'(HS_POL) ^ ~hs1_q;
    vs_d = logic'(VS_POL) ^ ~vs1_q;
  end
  // stage 2: output registers, reset to black with inactive sync
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col_q <= '0;
      hs_q <= ~logic'(HS_POL);
      vs_q <= ~logic'(VS_POL);
      activeVideo <= 1'b0;
      frameStart <= 1'b0;
    end else begin
      col_q <= col_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      activeVideo <= vis1_q;
      frameStart <= fs1_q;
    end
  end
  assign {vgaR, vgaG, vgaB} = col_q;
  assign vgaHs = hs_q;
  assign vgaVs = vs_q;
endmodule

// File: tb/tb_vga_sprite_raster.sv
// tb_vga_sprite_raster: reduced-timing bench with a per-pixel reference model; honours VGA_GRID_EN
module tb_vga_sprite_raster;
  localparam int HA = 80, HF = 4, HS = 8, HB = 8, VA = 60, VF = 2, VS = 2, VB = 4;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int N = 4, SW = 8, SH = 8, CW = 10, GSZ = 32;
  localparam logic [8:0] GRID_C = 9'b100100100;
  localparam logic [8:0] BG = 9'h049;

  logic clk = 1'b0, rstN = 1'b1;
  logic [N*CW-1:0] spriteX = '0, spriteY = '0;
  logic [N*9-1:0] spriteColor = '0;
  logic [N-1:0] spriteEn = '0;
  logic [8:0] bgColor = '0;
  logic [2:0] vgaR, vgaG, vgaB;
  logic vgaHs, vgaVs, activeVideo, frameStart;

  vga_sprite_raster #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COORD_W(CW), .COLOR_BITS(3), .N_SPRITES(N), .SPRITE_W(SW), .SPRITE_H(SH)
  ) dut (
    .clk(clk), .rstN(rstN), .spriteX(spriteX), .spriteY(spriteY), .spriteColor(spriteColor),
    .spriteEn(spriteEn), .bgColor(bgColor), .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
    .vgaHs(vgaHs), .vgaVs(vgaVs), .activeVideo(activeVideo), .frameStart(frameStart)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [8:0] col;
    logic use_bg, hs, vs, av, fs;
  } px_t;

  int total = 0, bad = 0;
  px_t d1, d2;
  int mh, mv, cyc, hl, vl, last_fs;
  bit fs_valid;
  int m_sx[N], m_sy[N];
  logic [8:0] m_sc[N];
  logic m_en[N];

  // what the screen should show at (x,y), from the current shadow sprite state
  function automatic px_t model_px(int x, int y);
    px_t p;
    int hit;
    hit = -1;
    p = '0;
    p.x = 10'(x);
    p.y = 10'(y);
    p.av = x < HA && y < VA;
    p.hs = !(x >= HA + HF && x < HA + HF + HS);
    p.vs = !(y >= VA + VF && y < VA + VF + VS);
    p.fs = x == 0 && y == 0;
    for (int i = N - 1; i >= 0; i--)
      if (m_en[i] && x >= m_sx[i] && x < m_sx[i] + SW && y >= m_sy[i] && y < m_sy[i] + SH) hit = i;
    if (p.av) begin
      if (hit >= 0) p.col = m_sc[hit];
`ifdef VGA_GRID_EN
      else if (x % GSZ == 0 || y % GSZ == 0) p.col = GRID_C;
`endif
      else p.use_bg = 1'b1;
    end
    return p;
  endfunction

  function automatic px_t rst_px();
    px_t p;
    p = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  task automatic check_out(input string tag);
    logic [12:0] obs, exp;
    obs = {vgaR, vgaG, vgaB, vgaHs, vgaVs, activeVideo, frameStart};
    exp = {d2.col, d2.hs, d2.vs, d2.av, d2.fs};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s x=%0d y=%0d observed=%h expected=%h", tag, d2.x, d2.y, obs, exp);
    end
  endtask

  task automatic step();
    px_t n;
    n = model_px(mh, mv);
    @(posedge clk);
    d2 = d1;
    if (d2.use_bg) d2.col = bgColor;
    d2.use_bg = 1'b0;
    d1 = n;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv + 1) % VT;
      if (mv == VA)
        for (int i = 0; i < N; i++) begin
          m_sx[i] = int'(spriteX[i*CW +: CW]);
          m_sy[i] = int'(spriteY[i*CW +: CW]);
          m_sc[i] = spriteColor[i*9 +: 9];
          m_en[i] = spriteEn[i];
        end
    end
    cyc++;
    #1 check_out("pix");
    if (!vgaHs) hl++;
    else begin
      if (hl > 0) begin
        total++;
        assert (hl == HS) else begin bad++; $error("FAIL hs_width observed=%0d expected=%0d", hl, HS); end
      end
      hl = 0;
    end
    if (!vgaVs) vl++;
    else begin
      if (vl > 0) begin
        total++;
        assert (vl == VS * HT) else begin bad++; $error("FAIL vs_width observed=%0d expected=%0d", vl, VS * HT); end
      end
      vl = 0;
    end
    if (frameStart) begin
      if (fs_valid) begin
        total++;
        assert (cyc - last_fs == HT * VT) else begin
          bad++;
          $error("FAIL frame_len observed=%0d expected=%0d", cyc - last_fs, HT * VT);
        end
      end
      last_fs = cyc;
      fs_valid = 1'b1;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    d1 = rst_px();
    d2 = rst_px();
    #1 check_out("rst_async");
    mh = 0;
    mv = 0;
    hl = 0;
    vl = 0;
    fs_valid = 1'b0;
    for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1 check_out("rst_hold");
    end
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic expect_px(input int x, input int y, input logic [8:0] c, input string tag);
    int k;
    k = 0;
    while (!(d2.av && d2.x == 10'(x) && d2.y == 10'(y)) && k < 2 * HT * VT) begin
      step();
      k++;
    end
    total++;
    assert (k < 2 * HT * VT) else begin bad++; $error("FAIL %s_timeout observed=%0d expected<%0d", tag, k, 2 * HT * VT); end
    total++;
    assert ({vgaR, vgaG, vgaB} === c) else begin
      bad++;
      $error("FAIL %s (%0d,%0d) observed=%h expected=%h", tag, x, y, {vgaR, vgaG, vgaB}, c);
    end
  endtask

  task automatic run_to_counter(input int x, input int y);
    int k;
    k = 0;
    while (!(mh == x && mv == y) && k < 2 * HT * VT) begin
      step();
      k++;
    end
    total++;
    assert (k < 2 * HT * VT) else begin bad++; $error("FAIL counter_timeout observed=%0d expected<%0d", k, 2 * HT * VT); end
  endtask

  int tx[12] = '{19, 20, 27, 28, 26, 30, 27, 31, 33, 76, 79, 1};
  int ty[12] = '{10, 10, 10, 10, 14, 14, 17, 19, 19, 30, 30, 31};
  logic [8:0] tc[12] = '{BG, 9'h1C0, 9'h1C0, BG, 9'h1C0, 9'h038, 9'h1C0, 9'h038, BG, 9'h007, 9'h007, BG};

  initial begin
    cyc = 0;
    last_fs = 0;
    #2 do_reset();
    spriteX = {10'd1020, 10'd76, 10'd24, 10'd20};
    spriteY = {10'd40, 10'd30, 10'd12, 10'd10};
    spriteColor = {9'h1FF, 9'h007, 9'h038, 9'h1C0};
    spriteEn = 4'b1111;
    bgColor = BG;
    expect_px(20, 10, BG, "no_sprite_before_load");
    for (int i = 0; i < 12; i++) expect_px(tx[i], ty[i], tc[i], "frame1");
    run_to_counter(0, 5);
    spriteX[9:0] = 10'd40;
    expect_px(20, 10, 9'h1C0, "old_pos_kept");
    expect_px(40, 10, BG, "new_pos_not_yet");
    expect_px(20, 10, BG, "old_pos_gone");
    expect_px(40, 10, 9'h1C0, "new_pos_shown");
    repeat (200) begin
      for (int i = 0; i < N; i++) begin
        spriteX[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 90));
        spriteY[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(1016, 1023)) : 10'($urandom_range(0, 70));
        spriteColor[i*9 +: 9] = 9'($urandom);
      end
      spriteEn = 4'($urandom);
      bgColor = 9'($urandom);
      repeat ($urandom_range(20, 150)) step();
    end
    run_to_counter(40, 30);
    do_reset();
    step();
    total++;
    assert (frameStart === 1'b0) else begin bad++; $error("FAIL fs_early observed=%b expected=0", frameStart); end
    step();
    total++;
    assert (frameStart === 1'b1) else begin bad++; $error("FAIL fs_after_reset observed=%b expected=1", frameStart); end
`ifdef VGA_GRID_EN
    expect_px(32, 5, GRID_C, "grid");
`endif
    repeat (HT * VT + 10) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
